multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
Iterative signed 32-bit multiply/divide unit in the execute stage; consumes mul/div R-type instructions issued from DX and produces the result plus the ready pulse (multdiv_RDY) that the hazard/stall logic waits on.
- Multiply: radix-2 shift-add with sign correction, one bit per cycle.
- Divide: restoring divide on magnitudes with sign fix-up, one bit per cycle.
- Uniform fixed latency for every operation, including exceptional cases.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count = WIDTH.

Ports:
clock  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
operandA  in  WIDTH  multiplicand / dividend, signed two's complement
operandB  in  WIDTH  multiplier / divisor, signed two's complement
ctrl_MULT  in  1  start-multiply strobe, sampled each rising edge
ctrl_DIV  in  1  start-divide strobe, sampled each rising edge
data_result  out  WIDTH  product low word / quotient
data_exception  out  1  overflow or divide-by-zero flag for data_result
data_resultRDY  out  1  one-cycle pulse: data_result/data_exception valid
busy  out  1  high while an operation is in flight

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0; all internal operand/accumulator registers cleared. Reset mid-operation aborts it; no RDY pulse is produced.
- States:
  - IDLE: waiting for a start strobe.
  - MUL: multiply iterations.
  - DIV: divide iterations.
  - DONE: result registered.
- Start rule: at a rising edge E0 with ctrl_MULT=1 or ctrl_DIV=1, operands are latched and the FSM enters MUL or DIV; counter=0; busy=1 from after E0.
- Start-strobe priority:
  - ctrl_MULT and ctrl_DIV both high: multiply wins.
  - A strobe in any state (MUL, DIV, DONE) aborts the current operation and restarts with the new operands. The aborted operation never pulses RDY.
- Iterations: one per edge, E1..E(WIDTH). Counter increments each edge. At the edge where counter reaches WIDTH, the FSM moves to DONE.
- Completion timing:
  - At edge E(WIDTH+1): data_result and data_exception are registered, data_resultRDY=1 and busy=0.
  - data_resultRDY is high for exactly one cycle (E(WIDTH+1) to E(WIDTH+2)).
  - Latency: start edge to RDY-high edge = WIDTH+1 = 33 edges.
- After RDY: the FSM returns to IDLE. data_result and data_exception hold their values until the next completion or reset; they are not cleared by a new start.
- Multiply arithmetic:
  - Full 2*WIDTH signed product is formed; data_result = low WIDTH bits.
  - data_exception=1 iff the product's upper WIDTH+1 bits are not all equal (result does not fit in signed WIDTH).
- Divide arithmetic:
  - Signed quotient, truncated toward zero; remainder discarded.
  - Quotient sign = sign(A) XOR sign(B).
- Divide by zero (operandB=0): data_result=0, data_exception=1; latency unchanged (33).
- Divide overflow (A=0x80000000, B=0xFFFFFFFF): data_result=0x80000000, data_exception=1; latency unchanged.
- Operand stability: operands only need to be valid at E0; later changes to operandA/operandB are ignored.
- Strobe handling: strobes are level-sampled each edge. A strobe held for N cycles restarts N times, so the issuer must drive strobes as single-cycle pulses.

Test Plan:
- Multiply, small signed: A=3, B=-4 pulse ctrl_MULT -> RDY exactly 33 edges later for one cycle, data_result=0xFFFFFFF4, exception=0, busy low from that edge.
- Multiply overflow: A=0x00010000, B=0x00010000 -> data_result=0x00000000, exception=1. Then A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception=0.
- Signed divide: A=-7, B=2 ctrl_DIV -> 0xFFFFFFFD, exception=0. A=100, B=-10 -> 0xFFFFFFF6. A=0x80000000, B=0xFFFFFFFF -> 0x80000000, exception=1.
- Divide by zero: A=5, B=0 -> RDY at edge 33, data_result=0, exception=1.
- Restart and priority:
  - ctrl_DIV with A=9, B=3, then ctrl_MULT with A=6, B=7 at edge 10 -> single RDY at edge 10+33, result=42; no RDY for the divide.
  - Both strobes together with A=6, B=3 -> result 18.
- Reset mid-op: start multiply, drop resetn at edge 15 -> outputs 0 immediately (asynchronous), no RDY ever for it. Release resetn, then a fresh operation 3*4 -> 12 at +33.

Source files
------------

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per clock, fixed WIDTH+1 edge latency.
//
// state  | meaning
// IDLE   | waiting for a start strobe
// MUL    | multiply iterations, one multiplier bit per edge
// DIV    | divide iterations, one quotient bit per edge
// DONE   | sign fix-up, result registered, RDY pulsed
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic               is_div_q;
  logic               neg_q;
  logic               dbz_q;
  logic               dovf_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] mcand_q;
  // Multiplier bits in MUL; dividend shifting out / quotient shifting in during DIV.
  logic [WIDTH-1:0]   shift_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvsr_q;

  logic [WIDTH-1:0]   a_mag_d;
  logic [WIDTH-1:0]   b_mag_d;
  logic [WIDTH:0]     rem_shift_d;
  logic [WIDTH-1:0]   rem_sub_d;
  logic               fits_d;
  logic [2*WIDTH-1:0] prod_fin_d;
  logic [WIDTH-1:0]   quo_fin_d;
  logic               mul_ovf_d;
  logic               start_d;
  logic               div_ovf_in_d;

  always_comb begin
    start_d      = ctrl_MULT | ctrl_DIV;
    a_mag_d      = operandA[WIDTH-1] ? -operandA : operandA;
    b_mag_d      = operandB[WIDTH-1] ? -operandB : operandB;
    div_ovf_in_d = (operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (operandB == {WIDTH{1'b1}});

    // Remainder stays below the divisor, so the trial difference fits in WIDTH bits.
    rem_shift_d  = {rem_q, shift_q[WIDTH-1]};
    fits_d       = rem_shift_d >= {1'b0, dvsr_q};
    rem_sub_d    = rem_shift_d[WIDTH-1:0] - dvsr_q;

    prod_fin_d   = neg_q ? -prod_q : prod_q;
    quo_fin_d    = neg_q ? -shift_q : shift_q;
    mul_ovf_d    = !((&prod_fin_d[2*WIDTH-1:WIDTH-1]) || !(|prod_fin_d[2*WIDTH-1:WIDTH-1]));
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      is_div_q       <= 1'b0;
      neg_q          <= 1'b0;
      dbz_q          <= 1'b0;
      dovf_q         <= 1'b0;
      prod_q         <= '0;
      mcand_q        <= '0;
      shift_q        <= '0;
      rem_q          <= '0;
      dvsr_q         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start_d) begin
      // A strobe in any state restarts; multiply wins when both are raised.
      state_q        <= ctrl_MULT ? S_MUL : S_DIV;
      count_q        <= '0;
      is_div_q       <= ~ctrl_MULT;
      neg_q          <= operandA[WIDTH-1] ^ operandB[WIDTH-1];
      dbz_q          <= ~ctrl_MULT & (operandB == '0);
      dovf_q         <= ~ctrl_MULT & div_ovf_in_d;
      prod_q         <= '0;
      mcand_q        <= {{WIDTH{1'b0}}, a_mag_d};
      shift_q        <= ctrl_MULT ? b_mag_d : a_mag_d;
      rem_q          <= '0;
      dvsr_q         <= b_mag_d;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          data_resultRDY <= 1'b0;
        end
        S_MUL: begin
          if (shift_q[0]) begin
            prod_q <= prod_q + mcand_q;
          end
          mcand_q <= mcand_q << 1;
          shift_q <= shift_q >> 1;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= S_DONE;
          end
        end
        S_DIV: begin
          rem_q   <= fits_d ? rem_sub_d : rem_shift_d[WIDTH-1:0];
          shift_q <= {shift_q[WIDTH-2:0], fits_d};
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q        <= S_IDLE;
          count_q        <= '0;
          busy           <= 1'b0;
          data_resultRDY <= 1'b1;
          if (!is_div_q) begin
            data_result    <= prod_fin_d[WIDTH-1:0];
            data_exception <= mul_ovf_d;
          end else if (dbz_q) begin
            data_result    <= '0;
            data_exception <= 1'b1;
          end else begin
            // MIN / -1 yields magnitude 2^(WIDTH-1) with no negation, i.e. MIN itself.
            data_result    <= quo_fin_d;
            data_exception <= dovf_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter: stimulus pushes expected results computed with
// plain signed arithmetic; a negedge monitor pops and checks on every RDY pulse.
module tb_multdiv_iter;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic          clock;
  logic          resetn;
  logic [W-1:0]  operandA;
  logic [W-1:0]  operandB;
  logic          ctrl_MULT;
  logic          ctrl_DIV;
  logic [W-1:0]  data_result;
  logic          data_exception;
  logic          data_resultRDY;
  logic          busy;

  multdiv_iter #(.WIDTH(W)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .operandA       (operandA),
    .operandB       (operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    logic [W-1:0] res;
    logic         exc;
    int           edge_n;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_rdy = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: full-precision signed arithmetic with the documented special cases.
  function automatic exp_t model(input bit m, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint p;
    int     q;
    e.edge_n = 0;
    if (m) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      e.res = p[W-1:0];
      e.exc = (p != longint'($signed(e.res)));
    end else if (b == 0) begin
      e.res = '0;
      e.exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      q     = $signed(a) / $signed(b);
      e.res = q;
      e.exc = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0, 1, 2, 3: return $urandom();
      4, 5:       return W'(int'($urandom_range(0, 40)) - 20);
      6: begin
        case ($urandom_range(0, 4))
          0:       return 32'h0000_0000;
          1:       return 32'h0000_0001;
          2:       return 32'hFFFF_FFFF;
          3:       return 32'h8000_0000;
          default: return 32'h7FFF_FFFF;
        endcase
      end
      default:    return W'($urandom_range(0, 32'hFFFF));
    endcase
  endfunction

  // Strobe lands on the next rising edge (E0); operands are scrambled afterwards.
  task automatic start_op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   e0;
    e0        = cyc + 1;
    operandA  = a;
    operandB  = b;
    ctrl_MULT = m;
    ctrl_DIV  = d;
    @(posedge clock);
    sb_q.delete();
    e        = model(m, a, b);
    e.edge_n = e0 + LAT;
    sb_q.push_back(e);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    operandA  = $urandom();
    operandB  = $urandom();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < LAT + 10 && sb_q.size() != 0; i++) @(negedge clock);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rdy_timeout actual=no_rdy required=rdy_at_edge_%0d", sb_q[0].edge_n);
      sb_q.delete();
    end
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (resetn) begin
      if (data_resultRDY) begin
        chk("rdy_single_cycle", {31'd0, prev_rdy}, 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rdy actual=rdy result=%h required=no_rdy", data_result);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("result", data_result, e.res);
          chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
          chk("latency_edge", W'(cyc), W'(e.edge_n));
          chk("busy_at_rdy", {31'd0, busy}, 32'd0);
        end
      end
      prev_rdy <= data_resultRDY;
    end else begin
      prev_rdy <= 1'b0;
    end
  end

  initial begin
    resetn    = 1'b0;
    operandA  = '0;
    operandB  = '0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    #3;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exception", {31'd0, data_exception}, 32'd0);
    chk("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    start_op(1, 0, 32'd3, 32'hFFFF_FFFC);          wait_drain();
    start_op(1, 0, 32'h0001_0000, 32'h0001_0000);  wait_drain();
    start_op(1, 0, 32'h7FFF_FFFF, 32'd1);          wait_drain();
    start_op(0, 1, 32'hFFFF_FFF9, 32'd2);          wait_drain();
    start_op(0, 1, 32'd100, 32'hFFFF_FFF6);        wait_drain();
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);  wait_drain();
    start_op(0, 1, 32'd5, 32'd0);                  wait_drain();

    // Divide aborted by a multiply at relative edge 10.
    start_op(0, 1, 32'd9, 32'd3);
    repeat (10) @(negedge clock);
    start_op(1, 0, 32'd6, 32'd7);
    wait_drain();

    start_op(1, 1, 32'd6, 32'd3);                  wait_drain();

    // Reset mid-multiply: outputs clear immediately, no RDY afterwards.
    start_op(1, 0, 32'h0000_1234, 32'h0000_0010);
    repeat (15) @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    sb_q.delete();
    chk("async_reset_result", data_result, 32'd0);
    chk("async_reset_exception", {31'd0, data_exception}, 32'd0);
    chk("async_reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (LAT + 5) @(negedge clock);
    start_op(1, 0, 32'd3, 32'd4);                  wait_drain();

    // Random mix, with occasional restarts landing before, on and after completion.
    for (int n = 0; n < 60; n++) begin
      bit       m;
      logic [W-1:0] a;
      logic [W-1:0] b;
      m = 1'($urandom_range(0, 1));
      a = rnd_operand();
      b = rnd_operand();
      start_op(m, ~m, a, b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 36)) @(negedge clock);
      end else begin
        wait_drain();
      end
    end
    wait_drain();
    repeat (LAT + 3) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
